// File: rtl/decode_pkg.sv
// Shared opcode map, ALU encodings and the decoded-instruction bundle for the decode stage.
// Bundle field widths are fixed here; the stage's width parameters must keep their defaults.
package decode_pkg;

  localparam int OPC_BITS = 6;
  localparam int RA_BITS  = 5;
  localparam int MA_BITS  = 8;
  localparam int IMM_BITS = 16;
  localparam int ALU_BITS = 4;

  localparam logic [OPC_BITS-1:0] OPC_LDI       = 6'h00;
  localparam logic [OPC_BITS-1:0] OPC_MOV       = 6'h01;
  localparam logic [OPC_BITS-1:0] OPC_LD        = 6'h02;
  localparam logic [OPC_BITS-1:0] OPC_ST        = 6'h03;
  localparam logic [OPC_BITS-1:0] OPC_ALU_FIRST = 6'h04;
  localparam logic [OPC_BITS-1:0] OPC_ALU_LAST  = 6'h11;

  typedef enum logic [ALU_BITS-1:0] {
    ALU_AND  = 4'd0,
    ALU_NAND = 4'd1,
    ALU_OR   = 4'd2,
    ALU_NOR  = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_XNOR = 4'd5,
    ALU_NOT  = 4'd6,
    ALU_SHL  = 4'd7,
    ALU_SHR  = 4'd8
  } alu_op_e;

  typedef struct packed {
    logic [RA_BITS-1:0]  rdst2;
    logic [RA_BITS-1:0]  rdst1;
    logic [RA_BITS-1:0]  rsrc2;
    logic [RA_BITS-1:0]  rsrc1;
    logic [IMM_BITS-1:0] imm;
    logic [MA_BITS-1:0]  maddr;
    logic [ALU_BITS-1:0] alu_op;
    logic                we2;
    logic                we1;
    logic                mem_rd;
    logic                mem_wr;
    logic                use_imm;
    logic                is_alu;
    logic                illegal;
  } bundle_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational split of one instruction word into a decoded bundle; unused fields are zero.
// Zero latency, no handshake.
module instr_field_decode import decode_pkg::*; #(
  parameter int INSTR_W = 32,
  parameter int OPC_W   = 6,
  parameter int RA_W    = 5,
  parameter int MA_W    = 8,
  parameter int IMM_W   = 16
) (
  input  logic [INSTR_W-1:0] instr_i,
  output bundle_t            bundle_o
);

  localparam int FLD_TOP = INSTR_W - OPC_W - 1;

  logic [OPC_W-1:0] opc;
  assign opc = instr_i[INSTR_W-1 -: OPC_W];

  always_comb begin
    bundle_o = '0;
    if (opc == OPC_LDI) begin
      bundle_o.rdst2   = instr_i[FLD_TOP -: RA_W];
      bundle_o.imm     = instr_i[IMM_W-1:0];
      bundle_o.we2     = 1'b1;
      bundle_o.use_imm = 1'b1;
    end else if (opc == OPC_MOV) begin
      bundle_o.rdst2 = instr_i[FLD_TOP -: RA_W];
      bundle_o.rsrc2 = instr_i[RA_W-1:0];
      bundle_o.we2   = 1'b1;
    end else if (opc == OPC_LD) begin
      bundle_o.rdst2  = instr_i[FLD_TOP -: RA_W];
      bundle_o.maddr  = instr_i[MA_W-1:0];
      bundle_o.we2    = 1'b1;
      bundle_o.mem_rd = 1'b1;
    end else if (opc == OPC_ST) begin
      bundle_o.maddr  = instr_i[FLD_TOP -: MA_W];
      bundle_o.rsrc2  = instr_i[RA_W-1:0];
      bundle_o.mem_wr = 1'b1;
    end else if (opc >= OPC_ALU_FIRST && opc <= OPC_ALU_LAST) begin
      bundle_o.rdst2  = instr_i[FLD_TOP -: RA_W];
      bundle_o.rdst1  = instr_i[FLD_TOP-RA_W -: RA_W];
      bundle_o.rsrc2  = instr_i[2*RA_W-1 -: RA_W];
      bundle_o.rsrc1  = instr_i[RA_W-1:0];
      bundle_o.we2    = 1'b1;
      bundle_o.we1    = 1'b1;
      bundle_o.is_alu = 1'b1;
      // Modulo-16 subtraction on the low nibble equals opc-4 over the whole ALU range.
      bundle_o.alu_op = opc[ALU_BITS-1:0] - OPC_ALU_FIRST[ALU_BITS-1:0];
    end else begin
      bundle_o.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/skid_buffer2.sv
// Two-entry skid buffer: output register plus one skid slot, one-cycle latency, full throughput.
// in_ready_o is a flop (next state != TWO), so downstream stalls never reach upstream combinationally.
module skid_buffer2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] out_q;
  logic [W-1:0] skid_q;
  logic         rdy_q;
  logic         acc;
  logic         dlv;

  assign acc = in_valid_i && rdy_q;
  assign dlv = (state_q != EMPTY) && out_ready_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (acc) state_d = ONE;
      ONE: begin
        if (acc && !dlv)      state_d = TWO;
        else if (!acc && dlv) state_d = EMPTY;
      end
      TWO:     if (dlv) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != TWO);
      if (flush) begin
        out_q <= '0;
      end else begin
        case (state_q)
          EMPTY: if (acc) out_q <= in_data_i;
          ONE: begin
            if (acc && dlv)       out_q  <= in_data_i;
            else if (acc && !dlv) skid_q <= in_data_i;
          end
          TWO:     if (dlv) out_q <= skid_q;
          default: out_q <= out_q;
        endcase
      end
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = out_q;

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: decode on accept, one-cycle latency, 2-entry skid buffer toward execute.
// Registered in_ready; tracks illegal deliveries in a sticky flag and a saturating counter.
module instr_decode_stage import decode_pkg::*; #(
  parameter int INSTR_W = 32,
  parameter int OPC_W   = 6,
  parameter int RA_W    = 5,
  parameter int MA_W    = 8,
  parameter int IMM_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RA_W-1:0]    out_rdst2,
  output logic [RA_W-1:0]    out_rdst1,
  output logic [RA_W-1:0]    out_rsrc2,
  output logic [RA_W-1:0]    out_rsrc1,
  output logic [IMM_W-1:0]   out_imm,
  output logic [MA_W-1:0]    out_maddr,
  output logic [3:0]         out_alu_op,
  output logic               out_we2,
  output logic               out_we1,
  output logic               out_mem_rd,
  output logic               out_mem_wr,
  output logic               out_use_imm,
  output logic               out_is_alu,
  output logic               out_illegal,
  output logic               illegal_seen,
  output logic [CNT_W-1:0]   illegal_cnt
);

  bundle_t          dec_bundle;
  bundle_t          out_bundle;
  logic             ill_beat;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  instr_field_decode #(
    .INSTR_W(INSTR_W),
    .OPC_W  (OPC_W),
    .RA_W   (RA_W),
    .MA_W   (MA_W),
    .IMM_W  (IMM_W)
  ) u_dec (
    .instr_i (in_instr),
    .bundle_o(dec_bundle)
  );

  skid_buffer2 #(
    .W($bits(bundle_t))
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (dec_bundle),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_bundle)
  );

  // A delivery coinciding with flush still counts: the beat already left the stage.
  assign ill_beat = out_valid && out_ready && out_bundle.illegal;

  always_comb begin
    seen_d = seen_q | ill_beat;
    cnt_d  = cnt_q;
    if (ill_beat && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      seen_q <= seen_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_rdst2    = out_bundle.rdst2;
  assign out_rdst1    = out_bundle.rdst1;
  assign out_rsrc2    = out_bundle.rsrc2;
  assign out_rsrc1    = out_bundle.rsrc1;
  assign out_imm      = out_bundle.imm;
  assign out_maddr    = out_bundle.maddr;
  assign out_alu_op   = out_bundle.alu_op;
  assign out_we2      = out_bundle.we2;
  assign out_we1      = out_bundle.we1;
  assign out_mem_rd   = out_bundle.mem_rd;
  assign out_mem_wr   = out_bundle.mem_wr;
  assign out_use_imm  = out_bundle.use_imm;
  assign out_is_alu   = out_bundle.is_alu;
  assign out_illegal  = out_bundle.illegal;
  assign illegal_seen = seen_q;
  assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage; a second copy with a 3-bit counter exercises saturation.
module tb_instr_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;

  logic        in_ready, out_valid;
  logic [4:0]  out_rdst2, out_rdst1, out_rsrc2, out_rsrc1;
  logic [15:0] out_imm;
  logic [7:0]  out_maddr;
  logic [3:0]  out_alu_op;
  logic        out_we2, out_we1, out_mem_rd, out_mem_wr, out_use_imm, out_is_alu, out_illegal;
  logic        illegal_seen;
  logic [15:0] illegal_cnt;

  logic        s_in_ready, s_out_valid;
  logic [4:0]  s_rdst2, s_rdst1, s_rsrc2, s_rsrc1;
  logic [15:0] s_imm;
  logic [7:0]  s_maddr;
  logic [3:0]  s_alu_op;
  logic        s_we2, s_we1, s_mem_rd, s_mem_wr, s_use_imm, s_is_alu, s_illegal;
  logic        s_illegal_seen;
  logic [2:0]  s_illegal_cnt;

  instr_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rdst2(out_rdst2), .out_rdst1(out_rdst1), .out_rsrc2(out_rsrc2), .out_rsrc1(out_rsrc1),
    .out_imm(out_imm), .out_maddr(out_maddr), .out_alu_op(out_alu_op),
    .out_we2(out_we2), .out_we1(out_we1), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
    .out_use_imm(out_use_imm), .out_is_alu(out_is_alu), .out_illegal(out_illegal),
    .illegal_seen(illegal_seen), .illegal_cnt(illegal_cnt)
  );

  instr_decode_stage #(.CNT_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_rdst2(s_rdst2), .out_rdst1(s_rdst1), .out_rsrc2(s_rsrc2), .out_rsrc1(s_rsrc1),
    .out_imm(s_imm), .out_maddr(s_maddr), .out_alu_op(s_alu_op),
    .out_we2(s_we2), .out_we1(s_we1), .out_mem_rd(s_mem_rd), .out_mem_wr(s_mem_wr),
    .out_use_imm(s_use_imm), .out_is_alu(s_is_alu), .out_illegal(s_illegal),
    .illegal_seen(s_illegal_seen), .illegal_cnt(s_illegal_cnt)
  );

  // Flag order: we2, we1, mem_rd, mem_wr, use_imm, is_alu, illegal
  localparam logic [6:0] F_WE2 = 7'b1000000;
  localparam logic [6:0] F_WE1 = 7'b0100000;
  localparam logic [6:0] F_MRD = 7'b0010000;
  localparam logic [6:0] F_MWR = 7'b0001000;
  localparam logic [6:0] F_IMM = 7'b0000100;
  localparam logic [6:0] F_ALU = 7'b0000010;
  localparam logic [6:0] F_ILL = 7'b0000001;

  logic [54:0] obs;
  assign obs = {out_rdst2, out_rdst1, out_rsrc2, out_rsrc1, out_imm, out_maddr, out_alu_op,
                out_we2, out_we1, out_mem_rd, out_mem_wr, out_use_imm, out_is_alu, out_illegal};

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [54:0] exp_b(input logic [4:0] rd2, input logic [4:0] rd1,
                                        input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [15:0] imm, input logic [7:0] ma,
                                        input logic [3:0] alu, input logic [6:0] fl);
    return {rd2, rd1, rs2, rs1, imm, ma, alu, fl};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'h0020_1234; out_ready = 1'b0; flush = 1'b0;
    tick; tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (obs !== 55'd0) begin n_bad++; $display("FAIL reset_fields: got %h want 0", obs); end
    n_cmp++; if (illegal_seen !== 1'b0) begin n_bad++; $display("FAIL reset_seen: got %b want 0", illegal_seen); end
    n_cmp++; if (illegal_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %h want 0", illegal_cnt); end
    rst_n = 1'b1; in_valid = 1'b0;
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_no_phantom: got %b want 0", out_valid); end
  endtask

  task automatic test_ldi;
    in_instr = 32'h0020_1234; in_valid = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ldi_valid: got %b want 1", out_valid); end
    n_cmp++; if (obs !== exp_b(5'd1, 5'd0, 5'd0, 5'd0, 16'h1234, 8'h00, 4'd0, F_WE2 | F_IMM)) begin
      n_bad++; $display("FAIL ldi_fields: got %h want %h", obs,
                        exp_b(5'd1, 5'd0, 5'd0, 5'd0, 16'h1234, 8'h00, 4'd0, F_WE2 | F_IMM));
    end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ldi_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_formats;
    logic [31:0] vi [3];
    logic [54:0] ve [3];
    vi[0] = 32'h04FF_ABC9; ve[0] = exp_b(5'd7, 5'd0, 5'd9,    5'd0, 16'h0, 8'h00, 4'd0, F_WE2);
    vi[1] = 32'h085F_FFA5; ve[1] = exp_b(5'd2, 5'd0, 5'd0,    5'd0, 16'h0, 8'hA5, 4'd0, F_WE2 | F_MRD);
    vi[2] = 32'h0D6B_FFF1; ve[2] = exp_b(5'd0, 5'd0, 5'h11,   5'd0, 16'h0, 8'h5A, 4'd0, F_MWR);
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = vi[i];
      tick;
      n_cmp++; if (out_valid !== 1'b1 || obs !== ve[i]) begin
        n_bad++; $display("FAIL format_%0d: got v=%b %h want v=1 %h", i, out_valid, obs, ve[i]);
      end
    end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_alu_stream;
    logic [5:0] opc;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      opc = 6'(i + 4);
      in_instr = {opc, 5'd3, 5'd4, 6'h2A, 5'd5, 5'd6};
      tick;
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b1 ||
                   obs !== exp_b(5'd3, 5'd4, 5'd5, 5'd6, 16'h0, 8'h00, 4'(i), F_WE2 | F_WE1 | F_ALU)) begin
        n_bad++; $display("FAIL alu_beat_%0d: got v=%b r=%b %h want alu_op %0d", i, out_valid, in_ready, obs, i);
      end
    end
    in_valid = 1'b0;
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL alu_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure;
    logic [54:0] ea, eb, ec;
    ea = exp_b(5'd10, 5'd0, 5'd20, 5'd0, 16'h0, 8'h00, 4'd0, F_WE2);
    eb = exp_b(5'd11, 5'd0, 5'd21, 5'd0, 16'h0, 8'h00, 4'd0, F_WE2);
    ec = exp_b(5'd12, 5'd0, 5'd22, 5'd0, 16'h0, 8'h00, 4'd0, F_WE2);
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = {6'h01, 5'd10, 16'h0, 5'd20};
    tick;
    n_cmp++; if (in_ready !== 1'b1 || obs !== ea) begin n_bad++; $display("FAIL bp_first: got r=%b %h want r=1 %h", in_ready, obs, ea); end
    in_instr = {6'h01, 5'd11, 16'h0, 5'd21};
    tick;
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== ea) begin
      n_bad++; $display("FAIL bp_second: got r=%b v=%b %h want r=0 v=1 %h", in_ready, out_valid, obs, ea);
    end
    in_instr = {6'h01, 5'd12, 16'h0, 5'd22};
    tick;
    n_cmp++; if (in_ready !== 1'b0 || obs !== ea) begin n_bad++; $display("FAIL bp_hold: got r=%b %h want r=0 %h", in_ready, obs, ea); end
    out_ready = 1'b1;
    tick;
    n_cmp++; if (in_ready !== 1'b1 || obs !== eb) begin n_bad++; $display("FAIL bp_release_b: got r=%b %h want r=1 %h", in_ready, obs, eb); end
    tick;
    n_cmp++; if (out_valid !== 1'b1 || obs !== ec) begin n_bad++; $display("FAIL bp_release_c: got v=%b %h want v=1 %h", out_valid, obs, ec); end
    in_valid = 1'b0;
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_illegal;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFFF_FFFF;
    tick;
    n_cmp++; if (out_valid !== 1'b1 || obs !== exp_b(5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 8'h00, 4'd0, F_ILL)) begin
      n_bad++; $display("FAIL ill_fields: got v=%b %h want only illegal set", out_valid, obs);
    end
    n_cmp++; if (illegal_seen !== 1'b0) begin n_bad++; $display("FAIL ill_seen_early: got %b want 0", illegal_seen); end
    tick; tick;
    in_valid = 1'b0;
    tick;
    n_cmp++; if (illegal_seen !== 1'b1) begin n_bad++; $display("FAIL ill_seen: got %b want 1", illegal_seen); end
    n_cmp++; if (illegal_cnt !== 16'd3) begin n_bad++; $display("FAIL ill_cnt3: got %0d want 3", illegal_cnt); end
    n_cmp++; if (s_illegal_cnt !== 3'd3) begin n_bad++; $display("FAIL ill_small_cnt3: got %0d want 3", s_illegal_cnt); end
    // Opcode 0x12 is the first undefined code.
    in_valid = 1'b1; in_instr = 32'h4BFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (i == 0) begin
        n_cmp++; if (obs !== exp_b(5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 8'h00, 4'd0, F_ILL)) begin
          n_bad++; $display("FAIL ill_opc12: got %h want only illegal set", obs);
        end
      end
    end
    in_valid = 1'b0;
    tick;
    n_cmp++; if (illegal_cnt !== 16'd9) begin n_bad++; $display("FAIL ill_cnt9: got %0d want 9", illegal_cnt); end
    n_cmp++; if (s_illegal_cnt !== 3'd7) begin n_bad++; $display("FAIL ill_small_sat: got %0d want 7", s_illegal_cnt); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h0000_1111;
    tick;
    in_instr = 32'h0000_2222;
    tick;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_pre_two: got %b want 0", in_ready); end
    flush = 1'b1; in_instr = 32'h0000_3333;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_state: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    n_cmp++; if (illegal_cnt !== 16'd9) begin n_bad++; $display("FAIL flush_cnt: got %0d want 9", illegal_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_ghost_%0d: got %b want 0", i, out_valid); end
    end
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFFF_FFFF;
    tick; tick;
    flush = 1'b1; out_ready = 1'b1;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_dlv_valid: got %b want 0", out_valid); end
    n_cmp++; if (illegal_cnt !== 16'd10) begin n_bad++; $display("FAIL flush_dlv_cnt: got %0d want 10", illegal_cnt); end
    n_cmp++; if (s_illegal_cnt !== 3'd7) begin n_bad++; $display("FAIL flush_small_sat: got %0d want 7", s_illegal_cnt); end
    tick;
    n_cmp++; if (out_valid !== 1'b0 || illegal_cnt !== 16'd10) begin
      n_bad++; $display("FAIL flush_after: got v=%b cnt=%0d want v=0 cnt=10", out_valid, illegal_cnt);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0020_1234;
    tick;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_pre: got %b want 1", out_valid); end
    rst_n = 1'b0;
    tick;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rmid_state: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    n_cmp++; if (obs !== 55'd0) begin n_bad++; $display("FAIL rmid_fields: got %h want 0", obs); end
    n_cmp++; if (illegal_seen !== 1'b0 || illegal_cnt !== 16'd0 || s_illegal_cnt !== 3'd0) begin
      n_bad++; $display("FAIL rmid_counters: got seen=%b cnt=%0d small=%0d want 0 0 0", illegal_seen, illegal_cnt, s_illegal_cnt);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_after: got %b want 0", out_valid); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = 32'h0;
    test_reset;
    test_ldi;
    test_formats;
    test_alu_stream;
    test_backpressure;
    test_illegal;
    test_flush;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
